// File: rtl/mu0_pkg.sv
// mu0_pkg: opcodes, ALU modes, FSM states and select encodings shared by the MU0 control slice.
package mu0_pkg;
  typedef enum logic [3:0] {LDA = 4'd0, STA, ADD, SUB, JMP, JGE, JNE, STP} opcode_e;
  typedef enum logic [1:0] {FETCH, EXECUTE, HALT} state_e;
  localparam logic [1:0] ALU_PASSY = 2'b00;
  localparam logic [1:0] ALU_ADD = 2'b01;
  localparam logic [1:0] ALU_INC = 2'b10;
  localparam logic [1:0] ALU_SUB = 2'b11;
  localparam logic SEL_ACC = 1'b0;
  localparam logic SEL_PC = 1'b1;
  localparam logic SEL_DIN = 1'b0;
  localparam logic SEL_IR = 1'b1;
  localparam logic ADDR_PC = 1'b0;
  localparam logic ADDR_IR = 1'b1;
  function automatic logic is_mem(input logic [3:0] f);
    return ~f[3] & ~f[2];
  endfunction
endpackage

// File: rtl/mu0_stall_timer.sv
// mu0_stall_timer: counts consecutive stalled memory cycles and flags a timeout on the TIMEOUT-th one.
module mu0_stall_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic active_i,
  input  logic ready_i,
  output logic timeout_o
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic stall;
  assign stall = active_i & ~ready_i;
  always_comb cnt_d = stall ? cnt_q + 1'b1 : '0;
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  // fires while the count is about to reach TIMEOUT, so the halt lands on that edge
  generate
    if (TIMEOUT > 0) begin : g_to
      assign timeout_o = stall & (cnt_q == CW'(TIMEOUT - 1));
    end else begin : g_no_to
      assign timeout_o = 1'b0;
    end
  endgenerate
endmodule

// File: rtl/mu0_control.sv
// mu0_control: MU0 fetch/execute sequencer with memory-ready stall and timeout halt.
// Optional MU0_CONTROL_PERF_EN adds Instr_Count/Stall_Count performance counters.
module mu0_control
  import mu0_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [3:0]  F,
  input  logic        N,
  input  logic        Z,
  input  logic        Mem_Ready,
  output logic        X_sel,
  output logic        Y_sel,
  output logic        Addr_sel,
  output logic [1:0]  M,
  output logic        PC_En,
  output logic        IR_En,
  output logic        Acc_En,
  output logic        Rd,
  output logic        Wr,
  output logic        Fetch,
  output logic        Halted,
`ifdef MU0_CONTROL_PERF_EN
  output logic [15:0] Instr_Count,
  output logic [15:0] Stall_Count,
`endif
  output logic        Error
);
  state_e state_q, state_d;
  logic error_q, timeout, active;
  assign active = (state_q == FETCH) | ((state_q == EXECUTE) & is_mem(F));
  mu0_stall_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk(Clk), .rst(Reset), .active_i(active), .ready_i(Mem_Ready), .timeout_o(timeout)
  );
  always_comb begin
    state_d = state_q;
    X_sel = SEL_ACC;
    Y_sel = SEL_DIN;
    Addr_sel = ADDR_PC;
    M = ALU_PASSY;
    {PC_En, IR_En, Acc_En, Rd, Wr, Halted} = '0;
    case (state_q)
      FETCH: begin
        Rd = 1'b1;
        X_sel = SEL_PC;
        M = ALU_INC;
        IR_En = Mem_Ready;
        PC_En = Mem_Ready;
        state_d = Mem_Ready ? EXECUTE : FETCH;
      end
      EXECUTE: begin
        state_d = is_mem(F) & ~Mem_Ready ? EXECUTE : FETCH;
        case (F)
          LDA: begin
            Addr_sel = ADDR_IR;
            Rd = 1'b1;
            Acc_En = Mem_Ready;
          end
          STA: begin
            Addr_sel = ADDR_IR;
            Wr = 1'b1;
          end
          ADD, SUB: begin
            Addr_sel = ADDR_IR;
            Rd = 1'b1;
            M = (F == SUB) ? ALU_SUB : ALU_ADD;
            Acc_En = Mem_Ready;
          end
          JMP, JGE, JNE: begin
            Y_sel = SEL_IR;
            PC_En = (F == JMP) | ((F == JGE) & ~N) | ((F == JNE) & ~Z);
          end
          STP: state_d = HALT;
          default: ;
        endcase
      end
      HALT: Halted = 1'b1;
      default: state_d = FETCH;
    endcase
    if (timeout) state_d = HALT;
    if (Reset) {PC_En, IR_En, Acc_En, Rd, Wr, Halted} = '0;
  end
  always_ff @(posedge Clk)
    if (Reset) begin
      state_q <= FETCH;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      error_q <= error_q | timeout;
    end
  assign Fetch = (state_q == FETCH) & ~Reset;
  assign Error = error_q;
`ifdef MU0_CONTROL_PERF_EN
  logic [15:0] instr_q, stall_q;
  always_ff @(posedge Clk)
    if (Reset) begin
      instr_q <= '0;
      stall_q <= '0;
    end else begin
      if ((state_q == EXECUTE) && (state_d != EXECUTE)) instr_q <= instr_q + 16'd1;
      if (active && !Mem_Ready && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
    end
  assign Instr_Count = instr_q;
  assign Stall_Count = stall_q;
`endif
endmodule

// File: tb/tb_mu0_control.sv
// tb_mu0_control: table-driven cycle vectors plus halt and perf-counter sequences for mu0_control.
module tb_mu0_control;
  logic Clk = 1'b0;
  logic Reset, N, Z, Mem_Ready;
  logic [3:0] F;
  logic X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En, Rd, Wr, Fetch, Halted, Error;
  logic [1:0] M;
`ifdef MU0_CONTROL_PERF_EN
  logic [15:0] Instr_Count, Stall_Count;
`endif
  mu0_control #(.TIMEOUT(4)) dut (
    .Clk(Clk), .Reset(Reset), .F(F), .N(N), .Z(Z), .Mem_Ready(Mem_Ready),
    .X_sel(X_sel), .Y_sel(Y_sel), .Addr_sel(Addr_sel), .M(M),
    .PC_En(PC_En), .IR_En(IR_En), .Acc_En(Acc_En), .Rd(Rd), .Wr(Wr),
    .Fetch(Fetch), .Halted(Halted),
`ifdef MU0_CONTROL_PERF_EN
    .Instr_Count(Instr_Count), .Stall_Count(Stall_Count),
`endif
    .Error(Error)
  );
  always #5 Clk = ~Clk;
  // {X_sel,Y_sel,Addr_sel,M,PC_En,IR_En,Acc_En,Rd,Wr,Fetch,Halted,Error}
  localparam logic [12:0] FOK    = 13'b1_0_0_10_1_1_0_1_0_1_0_0;
  localparam logic [12:0] FST    = 13'b1_0_0_10_0_0_0_1_0_1_0_0;
  localparam logic [12:0] RST_F  = 13'b1_0_0_10_0_0_0_0_0_0_0_0;
  localparam logic [12:0] LDA_E  = 13'b0_0_1_00_0_0_1_1_0_0_0_0;
  localparam logic [12:0] LDA_S  = 13'b0_0_1_00_0_0_0_1_0_0_0_0;
  localparam logic [12:0] ADD_E  = 13'b0_0_1_01_0_0_1_1_0_0_0_0;
  localparam logic [12:0] SUB_E  = 13'b0_0_1_11_0_0_1_1_0_0_0_0;
  localparam logic [12:0] STA_E  = 13'b0_0_1_00_0_0_0_0_1_0_0_0;
  localparam logic [12:0] JT     = 13'b0_1_0_00_1_0_0_0_0_0_0_0;
  localparam logic [12:0] JNT    = 13'b0_1_0_00_0_0_0_0_0_0_0_0;
  localparam logic [12:0] ZERO   = 13'b0;
  localparam logic [12:0] HLT    = 13'b0_0_0_00_0_0_0_0_0_0_1_0;
  localparam logic [12:0] HLT_E  = 13'b0_0_0_00_0_0_0_0_0_0_1_1;
  localparam logic [12:0] ERR    = 13'b0_0_0_00_0_0_0_0_0_0_0_1;
  typedef struct packed {
    logic rst;
    logic [3:0] f;
    logic n, z, rdy;
    logic [12:0] exp;
  } vec_t;
  vec_t v[$];
  int passed = 0, total = 0;
  logic [12:0] act;
  assign act = {X_sel, Y_sel, Addr_sel, M, PC_En, IR_En, Acc_En, Rd, Wr, Fetch, Halted, Error};
  function automatic vec_t mk(input logic r, input logic [3:0] f, input logic n, z, rdy, input logic [12:0] e);
    return '{rst: r, f: f, n: n, z: z, rdy: rdy, exp: e};
  endfunction
  task automatic check(input string name, input logic [15:0] a, input logic [15:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s got=%b expected=%b", name, a, e);
  endtask
  task automatic drive(input logic r, input logic [3:0] f, input logic n, z, rdy);
    @(negedge Clk);
    Reset = r; F = f; N = n; Z = z; Mem_Ready = rdy;
    #1;
  endtask
  initial begin
    Reset = 1'b1; F = '0; N = 1'b0; Z = 1'b0; Mem_Ready = 1'b1;
    repeat (2) @(posedge Clk);
    v.push_back(mk(1, 0, 0, 0, 1, RST_F));
    v.push_back(mk(0, 0, 0, 0, 1, FOK));
    v.push_back(mk(0, 0, 0, 0, 1, LDA_E));
    v.push_back(mk(0, 2, 0, 0, 1, FOK));
    v.push_back(mk(0, 2, 0, 0, 1, ADD_E));
    v.push_back(mk(0, 3, 0, 0, 1, FOK));
    v.push_back(mk(0, 3, 0, 0, 1, SUB_E));
    v.push_back(mk(0, 5, 1, 0, 1, FOK));
    v.push_back(mk(0, 5, 1, 0, 1, JNT));
    v.push_back(mk(0, 5, 0, 0, 1, FOK));
    v.push_back(mk(0, 5, 0, 0, 1, JT));
    v.push_back(mk(0, 6, 0, 1, 1, FOK));
    v.push_back(mk(0, 6, 0, 1, 1, JNT));
    v.push_back(mk(0, 4, 0, 0, 0, FST));
    v.push_back(mk(0, 4, 0, 0, 1, FOK));
    v.push_back(mk(0, 4, 0, 0, 0, JT));
    v.push_back(mk(0, 9, 0, 0, 1, FOK));
    v.push_back(mk(0, 9, 0, 0, 1, ZERO));
    v.push_back(mk(0, 1, 0, 0, 1, FOK));
    repeat (3) v.push_back(mk(0, 1, 0, 0, 0, STA_E));
    v.push_back(mk(0, 1, 0, 0, 1, STA_E));
    v.push_back(mk(0, 7, 0, 0, 1, FOK));
    v.push_back(mk(0, 7, 0, 0, 1, ZERO));
    v.push_back(mk(0, 7, 0, 0, 1, HLT));
    v.push_back(mk(0, 0, 0, 0, 0, HLT));
    v.push_back(mk(1, 0, 0, 0, 0, ZERO));
    repeat (3) v.push_back(mk(0, 0, 0, 0, 0, FST));
    v.push_back(mk(1, 0, 0, 0, 0, RST_F));
    repeat (4) v.push_back(mk(0, 0, 0, 0, 0, FST));
    v.push_back(mk(0, 0, 0, 0, 1, HLT_E));
    v.push_back(mk(1, 0, 0, 0, 1, ERR));
    v.push_back(mk(0, 0, 0, 0, 1, FOK));
    repeat (3) v.push_back(mk(0, 0, 0, 0, 0, LDA_S));
    v.push_back(mk(0, 0, 0, 0, 1, LDA_E));
    v.push_back(mk(0, 0, 0, 0, 1, FOK));
    foreach (v[i]) begin
      drive(v[i].rst, v[i].f, v[i].n, v[i].z, v[i].rdy);
      check($sformatf("vec%0d", i), {3'b0, act}, {3'b0, v[i].exp});
    end
    // STP then HALT must persist whatever the inputs do
    drive(1, 0, 0, 0, 1);
    drive(0, 7, 0, 0, 1);
    check("stp_fetch", {3'b0, act}, {3'b0, FOK});
    drive(0, 7, 0, 0, 1);
    check("stp_exec", {3'b0, act}, {3'b0, ZERO});
    for (int i = 0; i < 8; i++) begin
      drive(0, 4'(i), i[1], i[2], i[0]);
      check($sformatf("halt_hold%0d", i), {3'b0, act}, {3'b0, HLT});
    end
    drive(1, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    check("halt_reset_fetch", {15'b0, Fetch}, 16'd1);
`ifdef MU0_CONTROL_PERF_EN
    drive(1, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    drive(0, 4, 0, 0, 1);
    drive(0, 4, 0, 0, 1);
    drive(0, 7, 0, 0, 1);
    drive(0, 7, 0, 0, 1);
    drive(0, 7, 0, 0, 1);
    check("instr_count", Instr_Count, 16'd3);
    check("stall_count", Stall_Count, 16'd1);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mu0_control.md
Name: mu0_control

Overview:
- Multi-cycle fetch/execute sequencer for the MU0 processor.
- Decodes the 4-bit opcode held in IR and drives the datapath mux selects, register enables and memory strobes.
- Issues the 2-bit mode M consumed by the MU0 ALU: 00 pass Y, 01 X+Y, 10 X+1, 11 X-Y.
- Stalls on a memory ready handshake; halts on STP or on a memory timeout.

Parameters:
- TIMEOUT, 16: maximum consecutive stall cycles waiting for Mem_Ready before error. 0 disables the timeout.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- F  in  4  opcode, IR[15:12].
- N  in  1  Acc[15], negative flag.
- Z  in  1  Acc==0, zero flag.
- Mem_Ready  in  1  memory completes the current Rd/Wr this cycle.
- X_sel  out  1  ALU X source: 0 Acc, 1 PC.
- Y_sel  out  1  ALU Y source: 0 memory Din, 1 IR[11:0] zero-extended.
- Addr_sel  out  1  address source: 0 PC, 1 IR[11:0].
- M  out  2  ALU mode.
- PC_En  out  1  load PC from ALU Q.
- IR_En  out  1  load IR from Din.
- Acc_En  out  1  load Acc from ALU Q.
- Rd  out  1  memory read strobe.
- Wr  out  1  memory write strobe; Acc drives Dout.
- Fetch  out  1  high in the FETCH state.
- Halted  out  1  high in the HALT state.
- Error  out  1  sticky; set on memory timeout.

Behaviour:
- State register values: FETCH, EXECUTE, HALT. Reset drives state to FETCH and clears Error and the stall counter.
- While Reset=1, all enables and strobes are 0, Fetch=0 and Halted=0 regardless of state. Reset takes effect on any state, including mid-stall and HALT.
- Outputs are combinational decode of state, F, N, Z and Mem_Ready.
- Unused selects and M default to 0.

FETCH:
- Addr_sel=0, Rd=1, X_sel=1, M=10.
- IR_En and PC_En are asserted only when Mem_Ready=1; the state advances to EXECUTE on that same edge.
- While Mem_Ready=0, all enables are 0 and the state holds.

EXECUTE, by opcode:
- 0 LDA: Addr_sel=1, Rd=1, Y_sel=0, M=00, Acc_En=Mem_Ready.
- 1 STA: Addr_sel=1, Wr=1. Completes on Mem_Ready.
- 2 ADD: Addr_sel=1, Rd=1, X_sel=0, Y_sel=0, M=01, Acc_En=Mem_Ready.
- 3 SUB: as ADD, with M=11.
- 4 JMP: Y_sel=1, M=00, PC_En=1. Single cycle; ignores Mem_Ready.
- 5 JGE: as JMP, with PC_En=~N.
- 6 JNE: as JMP, with PC_En=~Z.
- 7 STP: no enables. The state goes to HALT.
- 8-15: treated as no-op. One cycle, then FETCH.
- Memory opcodes (0-3) hold in EXECUTE until Mem_Ready, then go to FETCH.
- A not-taken jump costs one cycle; PC already holds PC+1 from fetch.

HALT:
- Halted=1, no strobes or enables.
- Remains in HALT until Reset.

Stall counter:
- Counts consecutive cycles with Rd or Wr asserted and Mem_Ready=0.
- Clears when Mem_Ready=1 or when no access is in progress.
- If TIMEOUT>0 and the count reaches TIMEOUT, then on the next edge Error=1 and the state goes to HALT. No enable fires on that cycle.
- If Mem_Ready=1 arrives in the same cycle the count reaches TIMEOUT, Mem_Ready wins and the access completes normally.
- Counter width is $clog2(TIMEOUT+1), minimum 1.

Latency:
- Memory instructions: 2 cycles plus stalls.
- Jumps and no-ops: 2 cycles.

Optional Feature:
- Macro: MU0_CONTROL_PERF_EN.
- Defined:
  - Adds output Instr_Count [15:0]. It increments on each EXECUTE-to-FETCH or EXECUTE-to-HALT transition and wraps at FFFF to 0000.
  - Adds output Stall_Count [15:0]. It increments on each stalled cycle and saturates at FFFF.
  - Both counters clear on Reset.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Package mu0_pkg holds:
  - opcode enum: LDA=0, STA, ADD, SUB, JMP, JGE, JNE, STP.
  - ALU mode localparams: ALU_PASSY=2'b00, ALU_ADD=01, ALU_INC=10, ALU_SUB=11.
  - state enum: FETCH, EXECUTE, HALT.
  - select encodings: SEL_ACC/SEL_PC, SEL_DIN/SEL_IR.
- Sub-module mu0_stall_timer: stall counter plus timeout compare. Inputs are access-active and Mem_Ready; output is timeout.

Test Plan:
- Reset, Mem_Ready=1, F=0 (LDA) -> cycle 1: Fetch=1, Rd=1, M=10, IR_En=PC_En=1. Cycle 2: Addr_sel=1, M=00, Acc_En=1. Cycle 3: Fetch=1.
- ADD then SUB with Mem_Ready=1 -> EXECUTE M=01 then M=11; X_sel=0, Y_sel=0, Acc_En=1 each; Wr=0 throughout.
- JGE with N=1 -> PC_En=0. JGE with N=0 -> PC_En=1, M=00, Y_sel=1. JNE with Z=1 -> PC_En=0.
- STA with Mem_Ready low for 3 cycles -> Wr=1 held 4 cycles, no enables, then FETCH. F=7 -> Halted=1 persists; a Reset pulse returns to Fetch=1.
- TIMEOUT=4, Mem_Ready stuck 0 in FETCH -> after 4 stalled cycles Error=1, Halted=1, IR_En never asserted. Reset asserted mid-stall clears Error and the counter.
- MU0_CONTROL_PERF_EN defined, run LDA, JMP, STP -> Instr_Count=3. One injected stall -> Stall_Count=1.
